// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN streaming blocks: default word width,
// row layout selector, fill/hold stage state encodings and sizing helpers.
package cnn_stream_pkg;

  localparam int unsigned WORD_BITS_DEFAULT = 32;

  // Order in which the values of one row appear in the input stream.
  typedef enum logic {
    LAYOUT_PIX_MAJOR = 1'b0,  // k = x*CHANNELS + ch
    LAYOUT_CH_MAJOR  = 1'b1   // k = ch*WIDTH + x
  } layout_e;

  // Fill stage: collecting words, or holding a completed row that could
  // not yet move into the hold stage.
  typedef logic [0:0] fill_state_t;
  localparam fill_state_t FILL_FILLING = 1'b0;
  localparam fill_state_t FILL_FULL    = 1'b1;

  // Hold stage: output register empty, or presenting a row downstream.
  typedef logic [0:0] hold_state_t;
  localparam hold_state_t HOLD_EMPTY = 1'b0;
  localparam hold_state_t HOLD_VALID = 1'b1;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Counter width for n states; never below one bit so n = 1 stays legal.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_hold_stage.sv
// Output stage of the row unpacker: one row register with valid/last and a
// stall handshake towards the consumer.
module row_hold_stage
  import cnn_stream_pkg::*;
#(
  parameter int unsigned ROW_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [ROW_BITS-1:0] load_row,
  input  logic                load_last,
  input  logic                downstream_stall,
  output logic                ready,
  output logic [ROW_BITS-1:0] row,
  output logic                valid,
  output logic                last
);

  hold_state_t state;
  logic        last_q;

  // Occupancy: a new row takes priority, otherwise a hand-off empties the stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= HOLD_EMPTY;
      last_q <= 1'b0;
    end else if (load) begin
      state  <= HOLD_VALID;
      last_q <= load_last;
    end else if (state == HOLD_VALID && !downstream_stall) begin
      state  <= HOLD_EMPTY;
    end
  end

  // Row data needs no reset; it is only observed while valid.
  always_ff @(posedge clock) begin
    if (load) begin
      row <= load_row;
    end
  end

  assign valid = (state == HOLD_VALID);
  assign last  = valid && last_q;
  // Can take a row this edge if empty or if the current one leaves now.
  assign ready = (state == HOLD_EMPTY) || !downstream_stall;

endmodule

// File: rtl/row_unpacker.sv
// Unpacks a stream of packed words into full pixel rows. A fill stage
// demultiplexes word lanes into row positions; a hold stage presents the
// completed row downstream, giving one word per cycle sustained throughput.
module row_unpacker
  import cnn_stream_pkg::*;
#(
  parameter int unsigned WIDTH           = 28,
  parameter int unsigned CHANNELS        = 1,
  parameter int unsigned VALUE_BITS      = 8,
  parameter int unsigned WORD_BITS       = WORD_BITS_DEFAULT,
  parameter int unsigned VALUES_PER_WORD = 4,
  parameter int unsigned CH_MAJOR        = 1
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [WORD_BITS-1:0]                            in_data,
  input  logic                                            in_valid,
  input  logic                                            in_last,
  output logic                                            upstream_stall,
  output logic [WIDTH-1:0][CHANNELS-1:0][VALUE_BITS-1:0]  out_row,
  output logic                                            out_valid,
  output logic                                            out_last,
  input  logic                                            downstream_stall,
  output logic                                            err_short
);

  localparam int unsigned N        = WIDTH * CHANNELS;
  localparam int unsigned WPR      = ceil_div(N, VALUES_PER_WORD);
  localparam int unsigned WC       = cnt_bits(WPR);
  localparam layout_e     LAYOUT   = (CH_MAJOR != 0) ? LAYOUT_CH_MAJOR : LAYOUT_PIX_MAJOR;
  localparam int unsigned ROW_BITS = N * VALUE_BITS;

  typedef logic [WIDTH-1:0][CHANNELS-1:0][VALUE_BITS-1:0] row_t;

  if (VALUES_PER_WORD * VALUE_BITS > WORD_BITS) begin : g_bad_packing
    $error("row_unpacker: VALUES_PER_WORD*VALUE_BITS exceeds WORD_BITS");
  end

  // Stream index of row position (x, ch).
  function automatic int unsigned stream_index(input int unsigned x, input int unsigned ch);
    return (LAYOUT == LAYOUT_CH_MAJOR) ? (ch * WIDTH + x) : (x * CHANNELS + ch);
  endfunction

  function automatic int unsigned word_of(input int unsigned x, input int unsigned ch);
    return stream_index(x, ch) / VALUES_PER_WORD;
  endfunction

  function automatic int unsigned lane_of(input int unsigned x, input int unsigned ch);
    return stream_index(x, ch) % VALUES_PER_WORD;
  endfunction

  fill_state_t     fill_state;
  logic [WC-1:0]   widx;
  row_t            fill_row;
  row_t            row_next;
  logic            fill_last;
  logic            err_q;
  logic [31:0]     widx_ext;

  logic accept;
  logic last_word;
  logic complete;
  logic hold_ready;
  logic hold_load;
  row_t hold_row;
  logic hold_last;

  assign accept    = in_valid && (fill_state == FILL_FILLING);
  assign last_word = (widx == WC'(WPR - 1));
  assign complete  = accept && (last_word || in_last);
  assign widx_ext  = 32'(widx);

  // Lane demux: every position belonging to the current word takes its lane;
  // on a short frame, positions of later words are zero-filled. Lanes mapping
  // past the end of the row have no position and are dropped.
  always_comb begin
    row_next = fill_row;
    for (int unsigned x = 0; x < WIDTH; x++) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        if (word_of(x, ch) == widx_ext) begin
          row_next[x][ch] = in_data[lane_of(x, ch) * VALUE_BITS +: VALUE_BITS];
        end else if (in_last && word_of(x, ch) > widx_ext) begin
          row_next[x][ch] = '0;
        end
      end
    end
  end

  // A parked full row goes first; otherwise a completing row bypasses the
  // fill register straight into the hold stage.
  always_comb begin
    hold_load = 1'b0;
    hold_row  = row_next;
    hold_last = in_last;
    if (fill_state == FILL_FULL) begin
      hold_load = hold_ready;
      hold_row  = fill_row;
      hold_last = fill_last;
    end else if (complete) begin
      hold_load = hold_ready;
    end
  end

  // Fill stage control: word index, full/filling state, short-frame pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      fill_state <= FILL_FILLING;
      widx       <= '0;
      fill_last  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= accept && in_last && !last_word;
      if (complete) begin
        widx       <= '0;
        fill_last  <= in_last;
        fill_state <= hold_ready ? FILL_FILLING : FILL_FULL;
      end else if (accept) begin
        widx <= widx + 1'b1;
      end else if (fill_state == FILL_FULL && hold_ready) begin
        fill_state <= FILL_FILLING;
      end
    end
  end

  // Row buffer captures every accepted word; contents need no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      fill_row <= row_next;
    end
  end

  row_hold_stage #(
    .ROW_BITS (ROW_BITS)
  ) u_hold (
    .clock            (clock),
    .reset            (reset),
    .load             (hold_load),
    .load_row         (hold_row),
    .load_last        (hold_last),
    .downstream_stall (downstream_stall),
    .ready            (hold_ready),
    .row              (out_row),
    .valid            (out_valid),
    .last             (out_last)
  );

  assign upstream_stall = (fill_state == FILL_FULL);
  assign err_short      = err_q;

endmodule

// File: tb/tb_row_unpacker.sv
// Bench for row_unpacker: three instances (4x2 channel-major, 4x2
// pixel-major, 5x1) checked every cycle against a row-queue model, plus
// directed scenarios with literal expectations.
module tb_row_unpacker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Group AB: instances A and B share inputs (same row length, different layout).
  logic [31:0] ab_data;
  logic        ab_valid, ab_last, ab_ds;
  logic [31:0] c_data;
  logic        c_valid, c_last, c_ds;

  logic                   a_stall, a_valid, a_last, a_err;
  logic [3:0][1:0][7:0]   a_row;
  logic                   b_stall, b_valid, b_last, b_err;
  logic [3:0][1:0][7:0]   b_row;
  logic                   c_stall, c_valid_o, c_last_o, c_err;
  logic [4:0][0:0][7:0]   c_row;

  row_unpacker #(.WIDTH(4), .CHANNELS(2), .VALUE_BITS(8), .WORD_BITS(32),
                 .VALUES_PER_WORD(4), .CH_MAJOR(1)) u_a (
    .clock(clk), .reset(rst), .in_data(ab_data), .in_valid(ab_valid), .in_last(ab_last),
    .upstream_stall(a_stall), .out_row(a_row), .out_valid(a_valid), .out_last(a_last),
    .downstream_stall(ab_ds), .err_short(a_err));

  row_unpacker #(.WIDTH(4), .CHANNELS(2), .VALUE_BITS(8), .WORD_BITS(32),
                 .VALUES_PER_WORD(4), .CH_MAJOR(0)) u_b (
    .clock(clk), .reset(rst), .in_data(ab_data), .in_valid(ab_valid), .in_last(ab_last),
    .upstream_stall(b_stall), .out_row(b_row), .out_valid(b_valid), .out_last(b_last),
    .downstream_stall(ab_ds), .err_short(b_err));

  row_unpacker #(.WIDTH(5), .CHANNELS(1), .VALUE_BITS(8), .WORD_BITS(32),
                 .VALUES_PER_WORD(4), .CH_MAJOR(1)) u_c (
    .clock(clk), .reset(rst), .in_data(c_data), .in_valid(c_valid), .in_last(c_last),
    .upstream_stall(c_stall), .out_row(c_row), .out_valid(c_valid_o), .out_last(c_last_o),
    .downstream_stall(c_ds), .err_short(c_err));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", name, d, act, exp);
    end
  endtask

  // Model: values are kept in stream order k; up to two completed rows can be
  // pending (one presented, one parked), which is what drives upstream_stall.
  logic [63:0] fv [3];
  int          fk [3];
  logic [63:0] pv [3][2];
  logic        pl [3][2];
  int          pc [3];
  logic        perr [3];

  task automatic model_step(input int d, input int n, input logic v, input logic l,
                            input logic [31:0] data, input logic ds, input logic r);
    logic acc, hand, complete, clast;
    if (r) begin
      pc[d] = 0; fk[d] = 0; perr[d] = 1'b0;
      return;
    end
    complete = 1'b0; clast = 1'b0; perr[d] = 1'b0;
    acc  = v && (pc[d] < 2);
    hand = (pc[d] >= 1) && !ds;
    if (acc) begin
      for (int j = 0; j < 4; j++) begin
        if (fk[d] < n) begin
          fv[d][fk[d]*8 +: 8] = data[j*8 +: 8];
          fk[d]++;
        end
      end
      if (fk[d] == n) begin
        complete = 1'b1; clast = l;
      end else if (l) begin
        for (int k = fk[d]; k < n; k++) fv[d][k*8 +: 8] = 8'h00;
        complete = 1'b1; clast = 1'b1; perr[d] = 1'b1;
      end
    end
    if (hand) begin
      pv[d][0] = pv[d][1]; pl[d][0] = pl[d][1]; pc[d]--;
    end
    if (complete) begin
      pv[d][pc[d]] = fv[d]; pl[d][pc[d]] = clast; pc[d]++; fk[d] = 0;
    end
  endtask

  // Place stream-ordered values into out_row[x][ch] positions.
  function automatic logic [63:0] layout(input logic [63:0] vals, input int w, input int c, input int cm);
    logic [63:0] r;
    int k;
    r = '0;
    for (int x = 0; x < w; x++) begin
      for (int ch = 0; ch < c; ch++) begin
        k = (cm != 0) ? (ch * w + x) : (x * c + ch);
        r[(x*c + ch)*8 +: 8] = vals[k*8 +: 8];
      end
    end
    return r;
  endfunction

  task automatic check_dut(input int d, input int w, input int c, input int cm,
                           input logic stall, input logic valid, input logic last,
                           input logic err, input logic [63:0] row);
    chk("upstream_stall", d, 64'(stall), 64'(pc[d] == 2));
    chk("out_valid", d, 64'(valid), 64'(pc[d] >= 1));
    chk("err_short", d, 64'(err), 64'(perr[d]));
    if (pc[d] >= 1) begin
      chk("out_last", d, 64'(last), 64'(pl[d][0]));
      chk("out_row", d, row, layout(pv[d][0], w, c, cm));
    end
  endtask

  int a_hand = 0;
  int c_hand = 0;
  int c_stall_seen = 0;
  logic armed = 1'b0;

  // Compare process: advance the model on each rising edge, compare on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (a_valid && !ab_ds) a_hand++;
      if (c_valid_o && !c_ds) c_hand++;
      if (c_stall) c_stall_seen++;
      model_step(0, 8, ab_valid, ab_last, ab_data, ab_ds, rst);
      model_step(1, 8, ab_valid, ab_last, ab_data, ab_ds, rst);
      model_step(2, 5, c_valid, c_last, c_data, c_ds, rst);
      if (rst) armed = 1'b1;
      @(negedge clk);
      if (armed) begin
        check_dut(0, 4, 2, 1, a_stall, a_valid, a_last, a_err, 64'(a_row));
        check_dut(1, 4, 2, 0, b_stall, b_valid, b_last, b_err, 64'(b_row));
        check_dut(2, 5, 1, 1, c_stall, c_valid_o, c_last_o, c_err, 64'(c_row));
      end
    end
  end

  logic ab_acc, c_acc;

  task automatic step();
    ab_acc = ab_valid && !a_stall;
    c_acc  = c_valid && !c_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ab(input logic [31:0] w, input logic l);
    ab_data = w; ab_last = l; ab_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ab_acc) break;
    end
    if (!ab_acc) chk("ab_accept_timeout", 0, 64'd0, 64'd1);
    ab_valid = 1'b0; ab_last = 1'b0;
  endtask

  task automatic send_c(input logic [31:0] w, input logic l);
    c_data = w; c_last = l; c_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (c_acc) break;
    end
    if (!c_acc) chk("c_accept_timeout", 2, 64'd0, 64'd1);
    c_valid = 1'b0; c_last = 1'b0;
  endtask

  int nacc;

  initial begin
    rst = 1'b1;
    ab_data = '0; ab_valid = 1'b0; ab_last = 1'b0; ab_ds = 1'b0;
    c_data = '0; c_valid = 1'b0; c_last = 1'b0; c_ds = 1'b0;
    repeat (3) step();
    chk("reset_valid", 0, 64'(a_valid), 64'd0);
    chk("reset_stall", 0, 64'(a_stall), 64'd0);
    chk("reset_err", 0, 64'(a_err), 64'd0);
    chk("reset_last", 0, 64'(a_last), 64'd0);
    rst = 1'b0;
    step();

    // Two-word row, both layouts.
    send_ab(32'h03020100, 1'b0);
    chk("valid_before_word2", 0, 64'(a_valid), 64'd0);
    send_ab(32'h07060504, 1'b0);
    chk("valid_after_word2", 0, 64'(a_valid), 64'd1);
    chk("chmajor_r1c1", 0, 64'(a_row[1][1]), 64'h05);
    chk("chmajor_r3c0", 0, 64'(a_row[3][0]), 64'h03);
    chk("pixmajor_r1c1", 1, 64'(b_row[1][1]), 64'h03);
    chk("pixmajor_r3c1", 1, 64'(b_row[3][1]), 64'h07);
    step();

    // Five-value rows back-to-back: trailing lanes of word 2 are discarded.
    c_hand = 0; c_stall_seen = 0;
    for (int r = 0; r < 3; r++) begin
      send_c(32'h03020100 + 32'(r) * 32'h20202020, 1'b0);
      send_c(32'hEEEEEE04 + 32'(r) * 32'h20, 1'b0);
      if (r == 0) begin
        chk("w5_row0_x4", 2, 64'(c_row[4][0]), 64'h04);
        chk("w5_row0_x0", 2, 64'(c_row[0][0]), 64'h00);
      end
    end
    repeat (3) step();
    chk("w5_rows_out", 2, 64'(c_hand), 64'd3);
    chk("w5_no_stall", 2, 64'(c_stall_seen), 64'd0);

    // Backpressure: two rows buffered, third row blocked until release.
    ab_ds = 1'b1; a_hand = 0;
    send_ab(32'h03020100, 1'b0);
    send_ab(32'h07060504, 1'b0);
    send_ab(32'h13121110, 1'b0);
    send_ab(32'h17161514, 1'b0);
    chk("bp_stall", 0, 64'(a_stall), 64'd1);
    ab_data = 32'h23222120; ab_valid = 1'b1; nacc = 0;
    repeat (5) begin
      step();
      if (ab_acc) nacc++;
    end
    chk("bp_blocked", 0, 64'(nacc), 64'd0);
    chk("bp_row0_held", 0, 64'(a_row[3][1]), 64'h07);
    ab_ds = 1'b0;
    send_ab(32'h23222120, 1'b0);
    send_ab(32'h27262524, 1'b0);
    repeat (4) step();
    chk("bp_rows_out", 0, 64'(a_hand), 64'd3);

    // Short frame: in_last on the first word of a two-word row.
    send_ab(32'h03020100, 1'b1);
    chk("short_err", 0, 64'(a_err), 64'd1);
    chk("short_last", 0, 64'(a_last), 64'd1);
    chk("short_row", 0, 64'(a_row), 64'h0003000200010000);
    step();
    chk("short_err_pulse", 0, 64'(a_err), 64'd0);
    step();

    // Reset with a held row and a partial row pending.
    ab_ds = 1'b1;
    send_ab(32'h03020100, 1'b0);
    send_ab(32'h07060504, 1'b0);
    send_ab(32'h33323130, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 0, 64'(a_valid), 64'd0);
    chk("rst_mid_stall", 0, 64'(a_stall), 64'd0);
    ab_ds = 1'b0;
    send_ab(32'h0B0A0908, 1'b0);
    send_ab(32'h0F0E0D0C, 1'b0);
    chk("fresh_valid", 0, 64'(a_valid), 64'd1);
    chk("fresh_r0c0", 0, 64'(a_row[0][0]), 64'h08);
    chk("fresh_r3c1", 0, 64'(a_row[3][1]), 64'h0F);
    chk("fresh_last", 0, 64'(a_last), 64'd0);

    // Random traffic with occasional short frames, stalls and resets.
    for (int i = 0; i < 4000; i++) begin
      ab_valid = ($urandom_range(0, 9) < 7);
      ab_last  = ($urandom_range(0, 15) == 0);
      ab_data  = $urandom;
      ab_ds    = ($urandom_range(0, 9) < 4);
      c_valid  = ($urandom_range(0, 9) < 7);
      c_last   = ($urandom_range(0, 15) == 0);
      c_data   = $urandom;
      c_ds     = ($urandom_range(0, 9) < 4);
      rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    ab_valid = 1'b0; ab_last = 1'b0; ab_ds = 1'b0;
    c_valid = 1'b0; c_last = 1'b0; c_ds = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_unpacker.md
ROW_UNPACKER -- requirements
Module: row_unpacker

Interface
REQ-001 Parameter WIDTH, default 28: pixels per row.
REQ-002 Parameter CHANNELS, default 1: channels per pixel.
REQ-003 Parameter VALUE_BITS, default 8: bits per value.
REQ-004 Parameter WORD_BITS, default 32: bits per input word.
REQ-005 Parameter VALUES_PER_WORD, default 4: values packed per word; SHALL satisfy VALUES_PER_WORD*VALUE_BITS <= WORD_BITS (elaboration error otherwise).
REQ-006 Parameter CH_MAJOR, default 1: 1 = stream index k = ch*WIDTH + x; 0 = k = x*CHANNELS + ch.
REQ-007 clock  input  1  sole clock, rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 in_data  input  WORD_BITS  packed values; lane j = bits [j*VALUE_BITS +: VALUE_BITS].
REQ-010 in_valid  input  1  in_data valid.
REQ-011 in_last  input  1  word is final word of frame.
REQ-012 upstream_stall  output  1  word not accepted this cycle.
REQ-013 out_row  output  VALUE_BITS x [WIDTH][CHANNELS]  assembled row.
REQ-014 out_valid  output  1  out_row valid.
REQ-015 out_last  output  1  row is final row of frame.
REQ-016 downstream_stall  input  1  consumer not accepting.
REQ-017 err_short  output  1  one-cycle pulse: frame ended mid-row.

Function
REQ-018 N = WIDTH*CHANNELS; WORDS_PER_ROW = ceil(N/VALUES_PER_WORD); counters SHALL be at least 1 bit wide (N=1 legal).
REQ-019 Word accepted iff in_valid && !upstream_stall; value k of row taken from accepted word k/VALUES_PER_WORD, lane k%VALUES_PER_WORD.
REQ-020 Unused lanes of the final word of a row (N not multiple of VALUES_PER_WORD) SHALL be ignored; next row starts at lane 0 of next word.
REQ-021 Two row stages: fill (states FILLING, FULL) and hold (states EMPTY, VALID); out_valid = hold VALID.
REQ-022 Row handed off iff out_valid && !downstream_stall; hold then goes EMPTY unless a completed row enters same edge.
REQ-023 Completing word accepted at cycle t with hold EMPTY or handing off at t: row SHALL enter hold at t+1, out_valid=1 at t+1, fill restarts at index 0 and may accept at t+1 (no bubble; 1 word/cycle sustained).
REQ-024 Otherwise fill goes FULL; upstream_stall = fill FULL (registered, not combinational from downstream_stall); on hand-off at t', fill row moves to hold at t'+1 and fill returns to FILLING.
REQ-025 out_row, out_last SHALL be stable while out_valid && downstream_stall.
REQ-026 in_last on the completing word sets out_last for that row.
REQ-027 in_last on a non-completing word: remaining values zero-filled, row completes as in REQ-023/024 with out_last=1, err_short pulses high the cycle after acceptance.
REQ-028 in_valid while upstream_stall SHALL have no effect; in_last without in_valid ignored.

Reset
REQ-029 On reset: fill FILLING at index 0, hold EMPTY; out_valid=0, out_last=0, upstream_stall=0, err_short=0 on the cycle after reset is sampled.
REQ-030 Reset mid-row or with hold VALID SHALL discard all partial and held rows; row buffer contents need not be reset.

Structure
REQ-031 Shared package cnn_stream_pkg SHALL hold WORD_BITS default, layout enum (CH_MAJOR/PIX_MAJOR) and fill/hold state typedefs.
REQ-032 Hold stage SHALL be a sub-module row_hold_stage (row register + valid/last, stall handshake); lane demux and index mapping stay in row_unpacker.

Verification
REQ-033 WIDTH=4,CHANNELS=2,VPW=4,CH_MAJOR=1; words 0x03020100, 0x07060504 -> out_row[1][1]=0x05, out_row[3][0]=0x03, out_valid one cycle after word 2.
REQ-034 Same words, CH_MAJOR=0 -> out_row[1][1]=0x03, out_row[3][1]=0x07.
REQ-035 WIDTH=5,CHANNELS=1,VPW=4; three rows back-to-back, downstream_stall=0 -> upstream_stall never 1, three out_valid rows, lanes 1-3 of word 2 ignored.
REQ-036 WIDTH=4,CHANNELS=2; downstream_stall=1, send 3 rows -> row0 held stable, upstream_stall=1 after row1 completes, row2 not accepted; release -> rows 0,1,2 delivered in order, none lost.
REQ-037 in_last on first word of 2-word row -> out_row values 4..7 = 0, out_last=1, err_short single-cycle pulse.
REQ-038 reset asserted after 1 of 2 words with hold VALID -> out_valid=0 next cycle; next two words form a correct fresh row.
